// File: rtl/mc_tag_lookup.sv
// rtl/mc_tag_lookup.sv - tag lookup / victim selection / tag RAM writeback controller
module mc_tag_lookup #(
  parameter int N_WAYS    = 2,
  parameter int IDX_WIDTH = 8,
  parameter int TAG_WIDTH = 12,
  parameter int AGE_WIDTH = 2,
  parameter int WL        = (N_WAYS > 2) ? $clog2(N_WAYS) : 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          req_valid,
  output logic                          req_ready,
  input  logic [IDX_WIDTH-1:0]          req_idx,
  input  logic [TAG_WIDTH-1:0]          req_tag,
  input  logic                          req_write,
  output logic                          resp_valid,
  input  logic                          resp_ready,
  output logic                          resp_hit,
  output logic [WL-1:0]                 resp_way,
  output logic                          resp_evict,
  output logic [TAG_WIDTH-1:0]          resp_evict_tag,
  output logic                          init_done,
  output logic [IDX_WIDTH-1:0]          tr_idx,
  output logic                          tr_ena,
  input  logic [N_WAYS-1:0]             tr_valid,
  input  logic [N_WAYS-1:0]             tr_dirty,
  input  logic [N_WAYS*AGE_WIDTH-1:0]   tr_age,
  input  logic [N_WAYS*TAG_WIDTH-1:0]   tr_tag,
  output logic [IDX_WIDTH-1:0]          tw_idx,
  output logic [N_WAYS-1:0]             tw_ena,
  output logic [N_WAYS-1:0]             tw_valid_we,
  output logic [N_WAYS-1:0]             tw_dirty_we,
  output logic [N_WAYS-1:0]             tw_tag_we,
  output logic [N_WAYS-1:0]             tw_age_we,
  output logic                          tw_valid,
  output logic                          tw_dirty,
  output logic [TAG_WIDTH-1:0]          tw_tag,
  output logic [N_WAYS*AGE_WIDTH-1:0]   tw_age
);

  localparam logic [2:0] S_INIT    = 3'd0;
  localparam logic [2:0] S_IDLE    = 3'd1;
  localparam logic [2:0] S_LOOKUP  = 3'd2;
  localparam logic [2:0] S_COMPARE = 3'd3;
  localparam logic [2:0] S_RESP    = 3'd4;

  logic [2:0]                  r_state;
  logic [IDX_WIDTH:0]          r_cnt;
  logic [IDX_WIDTH-1:0]        r_idx;
  logic [TAG_WIDTH-1:0]        r_tag;
  logic                        r_write;
  logic [N_WAYS*AGE_WIDTH-1:0] r_age;

  logic                        w_hit;
  logic [WL-1:0]               w_hit_way;
  logic                        w_inv;
  logic [WL-1:0]               w_inv_way;
  logic [WL-1:0]               w_max_way;
  logic [AGE_WIDTH-1:0]        w_max_age;
  logic [WL-1:0]               w_sel;
  logic [AGE_WIDTH-1:0]        w_sel_age;
  logic [AGE_WIDTH-1:0]        w_cur_age;
  logic [N_WAYS*AGE_WIDTH-1:0] w_new_age;
  logic [N_WAYS*AGE_WIDTH-1:0] w_init_age;
  logic [N_WAYS-1:0]           w_sel_onehot;

  // Descending scans leave the lowest matching way as the winner.
  always_comb begin
    w_hit     = 1'b0;
    w_hit_way = '0;
    w_inv     = 1'b0;
    w_inv_way = '0;
    for (int w = N_WAYS - 1; w >= 0; w--) begin
      if (tr_valid[w] && (tr_tag[w*TAG_WIDTH +: TAG_WIDTH] == r_tag)) begin
        w_hit     = 1'b1;
        w_hit_way = WL'(w);
      end
      if (!tr_valid[w]) begin
        w_inv     = 1'b1;
        w_inv_way = WL'(w);
      end
    end
    w_max_way = '0;
    w_max_age = tr_age[AGE_WIDTH-1:0];
    for (int w = 1; w < N_WAYS; w++) begin
      if (tr_age[w*AGE_WIDTH +: AGE_WIDTH] > w_max_age) begin
        w_max_age = tr_age[w*AGE_WIDTH +: AGE_WIDTH];
        w_max_way = WL'(w);
      end
    end
    if (w_hit)      w_sel = w_hit_way;
    else if (w_inv) w_sel = w_inv_way;
    else            w_sel = w_max_way;
  end

  // LRU update: selected way becomes youngest, younger ways age by one.
  always_comb begin
    w_sel_age    = r_age[int'(resp_way)*AGE_WIDTH +: AGE_WIDTH];
    w_sel_onehot = N_WAYS'(1) << resp_way;
    w_new_age    = '0;
    w_init_age   = '0;
    w_cur_age    = '0;
    for (int w = 0; w < N_WAYS; w++) begin
      w_cur_age = r_age[w*AGE_WIDTH +: AGE_WIDTH];
      if (WL'(w) == resp_way)
        w_new_age[w*AGE_WIDTH +: AGE_WIDTH] = '0;
      else if (w_cur_age < w_sel_age)
        w_new_age[w*AGE_WIDTH +: AGE_WIDTH] = w_cur_age + AGE_WIDTH'(1);
      else
        w_new_age[w*AGE_WIDTH +: AGE_WIDTH] = w_cur_age;
      w_init_age[w*AGE_WIDTH +: AGE_WIDTH] = AGE_WIDTH'(w);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state        <= S_INIT;
      r_cnt          <= '0;
      r_idx          <= '0;
      r_tag          <= '0;
      r_write        <= 1'b0;
      r_age          <= '0;
      req_ready      <= 1'b0;
      resp_valid     <= 1'b0;
      resp_hit       <= 1'b0;
      resp_way       <= '0;
      resp_evict     <= 1'b0;
      resp_evict_tag <= '0;
      init_done      <= 1'b0;
      tr_idx         <= '0;
      tr_ena         <= 1'b0;
      tw_idx         <= '0;
      tw_ena         <= '0;
      tw_valid_we    <= '0;
      tw_dirty_we    <= '0;
      tw_tag_we      <= '0;
      tw_age_we      <= '0;
      tw_valid       <= 1'b0;
      tw_dirty       <= 1'b0;
      tw_tag         <= '0;
      tw_age         <= '0;
    end else begin
      tr_ena      <= 1'b0;
      tw_ena      <= '0;
      tw_valid_we <= '0;
      tw_dirty_we <= '0;
      tw_tag_we   <= '0;
      tw_age_we   <= '0;
      case (r_state)
        S_INIT: begin
          if (!r_cnt[IDX_WIDTH]) begin
            tw_ena      <= '1;
            tw_valid_we <= '1;
            tw_dirty_we <= '1;
            tw_tag_we   <= '1;
            tw_age_we   <= '1;
            tw_idx      <= r_cnt[IDX_WIDTH-1:0];
            tw_valid    <= 1'b0;
            tw_dirty    <= 1'b0;
            tw_tag      <= '0;
            tw_age      <= w_init_age;
            r_cnt       <= r_cnt + 1'b1;
          end else begin
            init_done <= 1'b1;
            r_state   <= S_IDLE;
          end
        end
        // req_ready rises one cycle after entry so a following lookup never
        // races the writeback issued on the way in.
        S_IDLE: begin
          if (req_ready && req_valid) begin
            r_idx     <= req_idx;
            r_tag     <= req_tag;
            r_write   <= req_write;
            req_ready <= 1'b0;
            tr_ena    <= 1'b1;
            tr_idx    <= req_idx;
            r_state   <= S_LOOKUP;
          end else begin
            req_ready <= 1'b1;
          end
        end
        S_LOOKUP: r_state <= S_COMPARE;
        S_COMPARE: begin
          resp_hit       <= w_hit;
          resp_way       <= w_sel;
          resp_evict     <= !w_hit && tr_valid[w_sel] && tr_dirty[w_sel];
          resp_evict_tag <= tr_tag[int'(w_sel)*TAG_WIDTH +: TAG_WIDTH];
          r_age          <= tr_age;
          resp_valid     <= 1'b1;
          r_state        <= S_RESP;
        end
        S_RESP: begin
          if (resp_ready) begin
            resp_valid <= 1'b0;
            tw_ena     <= '1;
            tw_age_we  <= '1;
            tw_idx     <= r_idx;
            tw_age     <= w_new_age;
            tw_valid   <= 1'b1;
            tw_tag     <= r_tag;
            if (resp_hit) begin
              tw_dirty_we <= w_sel_onehot & {N_WAYS{r_write}};
              tw_dirty    <= 1'b1;
            end else begin
              tw_valid_we <= w_sel_onehot;
              tw_tag_we   <= w_sel_onehot;
              tw_dirty_we <= w_sel_onehot;
              tw_dirty    <= r_write;
            end
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_INIT;
      endcase
    end
  end

endmodule

// File: tb/tb_mc_tag_lookup.sv
// tb/tb_mc_tag_lookup.sv - directed scoreboard bench for mc_tag_lookup with a tag RAM model
module tb_mc_tag_lookup;

  localparam int NW = 2;
  localparam int IW = 3;
  localparam int TW = 12;
  localparam int AW = 2;
  localparam int NI = 1 << IW;

  logic            clk = 1'b0;
  logic            rst;
  logic            req_valid, req_ready, req_write;
  logic [IW-1:0]   req_idx;
  logic [TW-1:0]   req_tag;
  logic            resp_valid, resp_ready, resp_hit, resp_evict;
  logic [0:0]      resp_way;
  logic [TW-1:0]   resp_evict_tag;
  logic            init_done;
  logic [IW-1:0]   tr_idx, tw_idx;
  logic            tr_ena;
  logic [NW-1:0]   tr_valid, tr_dirty;
  logic [NW*AW-1:0] tr_age, tw_age;
  logic [NW*TW-1:0] tr_tag;
  logic [NW-1:0]   tw_ena, tw_valid_we, tw_dirty_we, tw_tag_we, tw_age_we;
  logic            tw_valid, tw_dirty;
  logic [TW-1:0]   tw_tag;

  mc_tag_lookup #(.N_WAYS(NW), .IDX_WIDTH(IW), .TAG_WIDTH(TW), .AGE_WIDTH(AW)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_idx(req_idx),
    .req_tag(req_tag), .req_write(req_write),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_hit(resp_hit),
    .resp_way(resp_way), .resp_evict(resp_evict), .resp_evict_tag(resp_evict_tag),
    .init_done(init_done), .tr_idx(tr_idx), .tr_ena(tr_ena),
    .tr_valid(tr_valid), .tr_dirty(tr_dirty), .tr_age(tr_age), .tr_tag(tr_tag),
    .tw_idx(tw_idx), .tw_ena(tw_ena), .tw_valid_we(tw_valid_we),
    .tw_dirty_we(tw_dirty_we), .tw_tag_we(tw_tag_we), .tw_age_we(tw_age_we),
    .tw_valid(tw_valid), .tw_dirty(tw_dirty), .tw_tag(tw_tag), .tw_age(tw_age)
  );

  always #5 clk = ~clk;

  // Tag RAM model: one-cycle read latency, per-way per-field write enables.
  logic [NW-1:0] m_valid [NI];
  logic [NW-1:0] m_dirty [NI];
  logic [TW-1:0] m_tag   [NI][NW];
  logic [AW-1:0] m_age   [NI][NW];

  int            wr_cnt = 0;
  int            init_bad = 0;
  logic [IW:0]   init_exp = '0;
  logic [NW-1:0] last_valid_we, last_dirty_we, last_tag_we, last_age_we;
  logic          last_dirty;
  logic [IW-1:0] last_idx;

  always @(posedge clk) begin
    if (tr_ena) begin
      tr_valid <= m_valid[tr_idx];
      tr_dirty <= m_dirty[tr_idx];
      for (int w = 0; w < NW; w++) begin
        tr_tag[w*TW +: TW] <= m_tag[tr_idx][w];
        tr_age[w*AW +: AW] <= m_age[tr_idx][w];
      end
    end
  end

  always @(posedge clk) begin
    if (rst) init_exp <= '0;
    if (tw_ena != '0) begin
      wr_cnt        <= wr_cnt + 1;
      last_valid_we <= tw_valid_we;
      last_dirty_we <= tw_dirty_we;
      last_tag_we   <= tw_tag_we;
      last_age_we   <= tw_age_we;
      last_dirty    <= tw_dirty;
      last_idx      <= tw_idx;
      if (!init_done) begin
        if (tw_idx != init_exp[IW-1:0]) init_bad <= init_bad + 1;
        init_exp <= init_exp + 1'b1;
      end
      for (int w = 0; w < NW; w++) begin
        if (tw_ena[w]) begin
          if (tw_valid_we[w]) m_valid[tw_idx][w] <= tw_valid;
          if (tw_dirty_we[w]) m_dirty[tw_idx][w] <= tw_dirty;
          if (tw_tag_we[w])   m_tag[tw_idx][w]   <= tw_tag;
          if (tw_age_we[w])   m_age[tw_idx][w]   <= tw_age[w*AW +: AW];
        end
      end
    end
  end

  typedef struct packed {
    logic          hit;
    logic [0:0]    way;
    logic          ev;
    logic [TW-1:0] evtag;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
    end
  endtask

  task automatic wait_init(input string name, input int exp_cycles);
    int n;
    int wc0;
    n = 0;
    wc0 = wr_cnt;
    while (!init_done && n < 40) begin
      @(posedge clk);
      #1;
      n++;
    end
    check({name, "_cycles"}, 32'(n), 32'(exp_cycles));
    check({name, "_writes"}, 32'(wr_cnt - wc0), 32'(NI));
    check({name, "_idx_seq"}, 32'(init_bad), 0);
  endtask

  task automatic do_req(input logic [IW-1:0] idx, input logic [TW-1:0] tag, input logic wr,
                        input exp_t e_in, input int hold);
    int   n;
    int   wc0;
    exp_t e;
    logic snap_hit, snap_ev;
    logic [0:0] snap_way;
    logic [TW-1:0] snap_tag;
    exp_q.push_back(e_in);
    n = 0;
    while (!req_ready && n < 20) begin @(negedge clk); n++; end
    check("req_ready_timeout", 32'(n >= 20), 0);
    req_valid = 1'b1; req_idx = idx; req_tag = tag; req_write = wr;
    @(negedge clk);
    req_valid = 1'b0;
    n = 0;
    while (!resp_valid && n < 20) begin @(negedge clk); n++; end
    check("resp_valid_timeout", 32'(n >= 20), 0);
    snap_hit = resp_hit; snap_way = resp_way; snap_ev = resp_evict; snap_tag = resp_evict_tag;
    wc0 = wr_cnt;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check("hold_stable", 32'({resp_valid, resp_hit, resp_way, resp_evict, resp_evict_tag}),
            32'({1'b1, snap_hit, snap_way, snap_ev, snap_tag}));
      check("hold_no_write", 32'(tw_ena), 0);
      check("hold_req_ready", 32'(req_ready), 0);
    end
    e = exp_q.pop_front();
    check("resp_hit", 32'(resp_hit), 32'(e.hit));
    check("resp_way", 32'(resp_way), 32'(e.way));
    check("resp_evict", 32'(resp_evict), 32'(e.ev));
    if (!e.hit) check("resp_evict_tag", 32'(resp_evict_tag), 32'(e.evtag));
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("single_write_pulse", 32'(wr_cnt - wc0), 1);
    check("write_idx", 32'(last_idx), 32'(idx));
    check("age_we_all", 32'(last_age_we), 32'(2'b11));
  endtask

  initial begin
    int bad;
    int wc;
    rst = 1'b1; req_valid = 1'b0; req_idx = '0; req_tag = '0; req_write = 1'b0; resp_ready = 1'b0;
    tr_valid = '0; tr_dirty = '0; tr_age = '0; tr_tag = '0;
    repeat (3) @(negedge clk);
    check("rst_outputs", 32'({req_ready, resp_valid, init_done, tr_ena, tw_ena, resp_hit, tw_idx}), 0);
    rst = 1'b0;
    wait_init("init", 9);
    bad = 0;
    for (int i = 0; i < NI; i++)
      for (int w = 0; w < NW; w++)
        if (m_valid[i][w] !== 1'b0 || m_dirty[i][w] !== 1'b0 || m_age[i][w] !== AW'(w)) bad++;
    check("init_mem", 32'(bad), 0);
    @(negedge clk);

    do_req(3'd2, 12'h123, 1'b0, '{hit: 1'b0, way: 1'b0, ev: 1'b0, evtag: 12'h000}, 0);
    check("m1_we", 32'({last_valid_we, last_tag_we, last_dirty_we}), 32'(6'b01_01_01));
    check("m1_mem", 32'({m_valid[2], m_tag[2][0], m_age[2][0], m_age[2][1]}),
          32'({2'b01, 12'h123, 2'd0, 2'd1}));

    do_req(3'd2, 12'h123, 1'b1, '{hit: 1'b1, way: 1'b0, ev: 1'b0, evtag: 12'h000}, 0);
    check("h1_we", 32'({last_valid_we, last_tag_we, last_dirty_we, last_dirty}),
          32'(7'b00_00_01_1));
    check("h1_mem", 32'({m_dirty[2], m_age[2][0], m_age[2][1]}), 32'({2'b01, 2'd0, 2'd1}));

    do_req(3'd2, 12'h456, 1'b0, '{hit: 1'b0, way: 1'b1, ev: 1'b0, evtag: 12'h000}, 0);
    check("m2_we", 32'({last_tag_we, last_dirty_we, last_dirty}), 32'(5'b10_10_0));
    check("m2_mem", 32'({m_valid[2], m_tag[2][1], m_age[2][0], m_age[2][1]}),
          32'({2'b11, 12'h456, 2'd1, 2'd0}));

    do_req(3'd2, 12'h789, 1'b0, '{hit: 1'b0, way: 1'b0, ev: 1'b1, evtag: 12'h123}, 5);
    check("m3_mem", 32'({m_dirty[2], m_tag[2][0], m_age[2][0], m_age[2][1]}),
          32'({2'b00, 12'h789, 2'd0, 2'd1}));

    // Abort a lookup in COMPARE with reset.
    wc = 0;
    while (!req_ready && wc < 20) begin @(negedge clk); wc++; end
    check("abort_ready_timeout", 32'(wc >= 20), 0);
    req_valid = 1'b1; req_idx = 3'd5; req_tag = 12'habc; req_write = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    @(posedge clk);
    #1 rst = 1'b1;
    wc = wr_cnt;
    #1 check("abort_outputs", 32'({resp_valid, tw_ena, init_done, req_ready}), 0);
    repeat (2) @(negedge clk);
    check("abort_no_write", 32'(wr_cnt - wc), 0);
    rst = 1'b0;
    wait_init("reinit", 9);
    check("reinit_clears", 32'({m_valid[2], m_valid[5], m_age[2][0], m_age[2][1]}),
          32'({2'b00, 2'b00, 2'd0, 2'd1}));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
